// File: rtl/note_judge_pkg.sv
// Shared constants, state encoding and multiplier rule for the note judge.
// Fret bit order follows the controller: green is bit 0, orange is bit 4.
package note_judge_pkg;

  localparam int unsigned NOTE_W = 5;

  localparam int unsigned GREEN  = 0;
  localparam int unsigned RED    = 1;
  localparam int unsigned YELLOW = 2;
  localparam int unsigned BLUE   = 3;
  localparam int unsigned ORANGE = 4;

  localparam logic [22:0] WINDOW_DEFAULT = 23'd6000000;
  localparam logic [24:0] EIGHTH_NOTE    = 25'd13157895;

  localparam logic [7:0]  MULT_T2    = 8'd8;
  localparam logic [7:0]  MULT_T3    = 8'd16;
  localparam logic [7:0]  MULT_T4    = 8'd24;
  localparam logic [2:0]  MULT_MAX   = 3'd4;
  localparam logic [7:0]  STREAK_MAX = 8'd255;
  localparam logic [15:0] SCORE_MAX  = 16'hFFFF;

  typedef enum logic {
    StIdle,
    StArmed
  } state_e;

  function automatic logic [2:0] mult_from_streak(input logic [7:0] streak);
    logic [2:0] m;
    if (streak >= MULT_T4) begin
      m = MULT_MAX;
    end else if (streak >= MULT_T3) begin
      m = 3'd3;
    end else if (streak >= MULT_T2) begin
      m = 3'd2;
    end else begin
      m = 3'd1;
    end
    return m;
  endfunction

endpackage

// File: rtl/note_judge_input_sync.sv
// Two-flop synchronizer for asynchronous buttons with a rising-edge detector
// on the synchronized level.
module note_judge_input_sync #(
  parameter int unsigned Width = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [Width-1:0] i_d,
  output logic [Width-1:0] o_level,
  output logic [Width-1:0] o_rise
);

  logic [Width-1:0] r_meta;
  logic [Width-1:0] r_sync;
  logic [Width-1:0] r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= '0;
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_sync & ~r_prev;

endmodule

// File: rtl/note_judge.sv
// Judges player strums against the chord sampled after each beat tick and
// keeps score, streak and multiplier.
module note_judge
  import note_judge_pkg::*;
#(
  parameter logic [22:0] WINDOW       = WINDOW_DEFAULT,
  parameter int unsigned SAMPLE_DELAY = 2,
  parameter int unsigned HIT_POINTS   = 10
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              pause,
  input  logic              beat_pulse,
  input  logic [NOTE_W-1:0] exp_notes,
  input  logic [NOTE_W-1:0] frets,
  input  logic              strum,
  output logic              hit,
  output logic              miss,
  output logic              overstrum,
  output logic [15:0]       score,
  output logic [7:0]        streak,
  output logic [2:0]        multiplier,
  output logic [NOTE_W-1:0] target
);

  logic [NOTE_W-1:0] w_frets_s;
  logic [NOTE_W-1:0] w_unused_frets_rise;
  logic              w_unused_strum_level;
  logic              w_strum_rise;

  note_judge_input_sync #(
    .Width(NOTE_W)
  ) u_frets_sync (
    .i_clk  (CLOCK_50),
    .i_rst  (reset),
    .i_d    (frets),
    .o_level(w_frets_s),
    .o_rise (w_unused_frets_rise)
  );

  note_judge_input_sync #(
    .Width(1)
  ) u_strum_sync (
    .i_clk  (CLOCK_50),
    .i_rst  (reset),
    .i_d    (strum),
    .o_level(w_unused_strum_level),
    .o_rise (w_strum_rise)
  );

  // Beat delay line keeps shifting while paused; only its output is gated.
  logic [SAMPLE_DELAY-1:0] r_beat_sr;

  if (SAMPLE_DELAY > 1) begin : g_beat_multi
    always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
        r_beat_sr <= '0;
      end else begin
        r_beat_sr <= {r_beat_sr[SAMPLE_DELAY-2:0], beat_pulse};
      end
    end
  end else begin : g_beat_single
    always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
        r_beat_sr <= '0;
      end else begin
        r_beat_sr <= beat_pulse;
      end
    end
  end

  state_e            r_state, w_state_nxt;
  logic [22:0]       r_timer, w_timer_nxt;
  logic [NOTE_W-1:0] r_target, w_target_nxt;
  logic [15:0]       r_score, w_score_nxt;
  logic [7:0]        r_streak, w_streak_nxt;
  logic              r_hit, w_hit_nxt;
  logic              r_miss, w_miss_nxt;
  logic              r_over, w_over_nxt;

  logic              w_sample_now;
  logic              w_strum_edge;
  logic              w_arm_new;
  logic              w_old_miss;
  logic              w_eff_armed;
  logic [NOTE_W-1:0] w_eff_target;
  logic [2:0]        w_mult;
  logic [31:0]       w_points;
  logic [31:0]       w_score_sum;

  assign w_sample_now = r_beat_sr[SAMPLE_DELAY-1] & ~pause;
  assign w_strum_edge = w_strum_rise & ~pause;
  assign w_arm_new    = w_sample_now && (exp_notes != '0);
  assign w_old_miss   = w_sample_now && (r_state == StArmed);
  // A same-cycle strum sees the chord sampled in that cycle, not the old one.
  assign w_eff_armed  = w_sample_now ? (exp_notes != '0) : (r_state == StArmed);
  assign w_eff_target = w_arm_new ? exp_notes : r_target;

  assign w_mult      = mult_from_streak(r_streak);
  assign w_points    = 32'(HIT_POINTS) * 32'(w_mult);
  assign w_score_sum = 32'(r_score) + w_points;

  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer;
    w_target_nxt = r_target;
    w_score_nxt  = r_score;
    w_streak_nxt = r_streak;
    w_hit_nxt    = 1'b0;
    w_miss_nxt   = 1'b0;
    w_over_nxt   = 1'b0;

    if (!pause) begin
      if (w_arm_new) begin
        w_state_nxt  = StArmed;
        w_target_nxt = exp_notes;
        w_timer_nxt  = WINDOW - 23'd1;
      end else if (w_sample_now) begin
        w_state_nxt  = StIdle;
        w_target_nxt = '0;
        w_timer_nxt  = '0;
      end else if (r_state == StArmed && r_timer != '0) begin
        w_timer_nxt = r_timer - 23'd1;
      end

      if (w_strum_edge && w_eff_armed) begin
        w_state_nxt  = StIdle;
        w_target_nxt = '0;
        w_timer_nxt  = '0;
        if (w_frets_s == w_eff_target) begin
          w_hit_nxt   = 1'b1;
          w_score_nxt = (w_score_sum > 32'(SCORE_MAX)) ? SCORE_MAX : w_score_sum[15:0];
          // A replaced note still breaks the streak before this hit counts.
          if (w_old_miss) begin
            w_streak_nxt = 8'd1;
          end else if (r_streak != STREAK_MAX) begin
            w_streak_nxt = r_streak + 8'd1;
          end
        end else begin
          w_miss_nxt   = 1'b1;
          w_streak_nxt = '0;
        end
      end else if (w_old_miss) begin
        w_miss_nxt   = 1'b1;
        w_streak_nxt = '0;
      end else if (w_strum_edge) begin
        w_over_nxt   = 1'b1;
        w_streak_nxt = '0;
      end else if (r_state == StArmed && r_timer == '0) begin
        w_miss_nxt   = 1'b1;
        w_streak_nxt = '0;
        w_state_nxt  = StIdle;
        w_target_nxt = '0;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state  <= StIdle;
      r_timer  <= '0;
      r_target <= '0;
      r_score  <= '0;
      r_streak <= '0;
      r_hit    <= 1'b0;
      r_miss   <= 1'b0;
      r_over   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_target <= w_target_nxt;
      r_score  <= w_score_nxt;
      r_streak <= w_streak_nxt;
      r_hit    <= w_hit_nxt;
      r_miss   <= w_miss_nxt;
      r_over   <= w_over_nxt;
    end
  end

  assign hit        = r_hit;
  assign miss       = r_miss;
  assign overstrum  = r_over;
  assign score      = r_score;
  assign streak     = r_streak;
  assign multiplier = w_mult;
  assign target     = r_target;

endmodule

// File: doc/note_judge.md
Name: note_judge

Overview:
- Receiving end of the note stream. Consumes the per-eighth-note expected-chord vector (5 frets) and its beat pulse.
- Opens a timing window for each non-empty chord.
- Judges the player's synchronized fret and strum inputs against the chord, producing hit, miss and overstrum pulses plus score, streak and multiplier.
- Sits between the note sender and the display/score logic on the 50 MHz domain.

Parameters:
- WINDOW, 23'd6000000, window length in cycles (about 120 ms at 50 MHz); 1 to 2^23-1.
- SAMPLE_DELAY, 2, cycles from beat_pulse to sampling exp_notes (covers the sender's tick-to-notes latency); 1 to 4.
- HIT_POINTS, 10, base points per hit.

Ports:
- CLOCK_50  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pause  in  1  freeze: timer holds, strums and samples ignored
- beat_pulse  in  1  one-cycle eighth-note tick from the sender
- exp_notes  in  5  expected chord; bit0 = green … bit4 = orange; 0 = no note
- frets  in  5  raw fret buttons, active-high, asynchronous
- strum  in  1  raw strum bar, active-high, asynchronous
- hit  out  1  one-cycle pulse on a correct strum
- miss  out  1  one-cycle pulse on a wrong strum or window expiry
- overstrum  out  1  one-cycle pulse on a strum with no open window
- score  out  16  accumulated score, saturating
- streak  out  8  consecutive hits, saturating at 255
- multiplier  out  3  1..4
- target  out  5  chord currently being judged; 0 when idle

Behaviour:
- Reset (async, any time including mid-window): state IDLE; timer 0; target, score, streak 0; multiplier 1; all pulses 0; sync/delay pipelines cleared.
- Input conditioning:
  - frets and strum each pass through a 2-flop synchronizer.
  - strum_edge is the rising edge of the synchronized strum, giving 3-cycle input latency.
  - Holding strum produces only one edge.
- Sampling:
  - beat_pulse goes through a SAMPLE_DELAY-stage shift register.
  - sample_now = its output AND NOT pause.
  - A beat_pulse arriving while pause=1 is still shifted; it is dropped only if pause=1 on its sample_now cycle.
- States IDLE and ARMED. Precedence in one cycle: sample_now, then strum_edge, then expiry.
- IDLE:
  - sample_now with exp_notes≠0: latch target, timer←WINDOW-1, go to ARMED.
  - sample_now with exp_notes=0: stay in IDLE.
  - strum_edge (not paused): overstrum=1, streak←0.
- ARMED:
  - Timer decrements each unpaused cycle.
  - strum_edge with synced frets == target exactly (extra frets count as wrong): hit=1, go to IDLE.
  - strum_edge with any other fret pattern: miss=1, go to IDLE.
  - Timer reaches 0 with no strum: miss=1, go to IDLE.
  - sample_now while still ARMED:
    - Old note: miss=1.
    - New note: if exp_notes≠0, re-arm with the new chord and reload the timer, else go to IDLE.
    - A strum_edge in the same cycle is judged against the new chord.
- Scoring on hit:
  - points = HIT_POINTS × multiplier, using the multiplier before the hit.
  - score saturates at 16'hFFFF.
  - streak←streak+1, saturating at 255.
- On miss or overstrum: streak←0; score unchanged.
- multiplier is combinational from the registered streak: 0–7→1, 8–15→2, 16–23→3, ≥24→4.
- target is registered and returns to 0 on leaving ARMED.
- hit, miss and overstrum are registered and mutually exclusive in any cycle.
- pause=1: timer, state and score are held; strum edges are discarded (not queued).

Decomposition:
- Shared package holds:
  - Fret bit indices (GREEN=0 … ORANGE=4) and NOTE_W=5.
  - State encoding IDLE/ARMED.
  - Multiplier thresholds (8/16/24) and MULT_MAX=4.
  - Default WINDOW alongside EIGHTH_NOTE=25'd13157895.
- One sub-module, input_sync: a 2-flop synchronizer plus rising-edge detector, parameterized by width, instantiated for frets (level only) and strum (edge).

Test Plan:
- Settings for all scenarios: WINDOW=20, SAMPLE_DELAY=2.
- Clean hit:
  - Stimulus: exp_notes=5'b00101, beat_pulse, then frets=00101 and a strum 5 cycles after arming.
  - Required: hit pulse once; score=10; streak=1; target returns to 0.
- Wrong chord plus timeout:
  - Stimulus: first chord 00111 strummed with frets 00101; second chord 01010 with no strum.
  - Required: miss on the strum; miss exactly 20 cycles after the second arming; streak=0.
- Multiplier and saturation:
  - Stimulus: 24 consecutive hits, then one more.
  - Required: multiplier reads 4 after hit 24; score after hit 25 = 10·8 + 20·8 + 30·8 + 40 = 520.
  - Separately: preload score near 16'hFFF0 via hits with HIT_POINTS=1000; score saturates at 16'hFFFF.
- Overstrum and re-arm collision:
  - Stimulus: strum while IDLE; then sample 01011 while ARMED on 00111.
  - Required: overstrum pulse with streak cleared; miss for 00111; target=01011 with timer reloaded.
- Pause and reset:
  - Stimulus: pause for 50 cycles mid-window, strumming during the pause.
  - Required: no pulses during pause; the window resumes with its remaining count.
  - Stimulus: assert reset asynchronously mid-window.
  - Required: all outputs return to reset values immediately; multiplier=1.
